// File: rtl/riscv_pkg.sv
// Shared RV64IM definitions for the decode/issue and execute stages.
//   XLEN, NREG : datapath width and architectural register count
//   op_e, OP_W : decoded operation enum and its encoding width
//   OPC_*, F7_*: RISC-V major opcode and funct7 constants
//   decode_op  : maps a 32-bit instruction word to op_e
package riscv_pkg;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int OP_W = 6;

    // OP_ILLEGAL is encoding 0 so that a reset output slot reads as all zero.
    typedef enum logic [OP_W-1:0] {
        OP_ILLEGAL,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
        OP_ADDW, OP_SUBW, OP_SLLW, OP_SRLW, OP_SRAW,
        OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADDIW, OP_SLLIW, OP_SRLIW, OP_SRAIW,
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR
    } op_e;

    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    function automatic op_e decode_op(input logic [31:0] instr);
        logic [6:0] f7;
        logic [2:0] f3;
        op_e        op;
        f7 = instr[31:25];
        f3 = instr[14:12];
        op = OP_ILLEGAL;
        case (instr[6:0])
            OPC_OP: begin
                if (f7 == F7_BASE) begin
                    case (f3)
                        3'd0: op = OP_ADD;  3'd1: op = OP_SLL;
                        3'd2: op = OP_SLT;  3'd3: op = OP_SLTU;
                        3'd4: op = OP_XOR;  3'd5: op = OP_SRL;
                        3'd6: op = OP_OR;   default: op = OP_AND;
                    endcase
                end else if (f7 == F7_ALT) begin
                    if (f3 == 3'd0)      op = OP_SUB;
                    else if (f3 == 3'd5) op = OP_SRA;
                end else if (f7 == F7_MULDIV) begin
                    case (f3)
                        3'd0: op = OP_MUL;  3'd1: op = OP_MULH;
                        3'd2: op = OP_MULHSU; 3'd3: op = OP_MULHU;
                        3'd4: op = OP_DIV;  3'd5: op = OP_DIVU;
                        3'd6: op = OP_REM;  default: op = OP_REMU;
                    endcase
                end
            end
            OPC_OP32: begin
                if (f7 == F7_BASE) begin
                    if (f3 == 3'd0)      op = OP_ADDW;
                    else if (f3 == 3'd1) op = OP_SLLW;
                    else if (f3 == 3'd5) op = OP_SRLW;
                end else if (f7 == F7_ALT) begin
                    if (f3 == 3'd0)      op = OP_SUBW;
                    else if (f3 == 3'd5) op = OP_SRAW;
                end else if (f7 == F7_MULDIV) begin
                    case (f3)
                        3'd0: op = OP_MULW;  3'd4: op = OP_DIVW;
                        3'd5: op = OP_DIVUW; 3'd6: op = OP_REMW;
                        3'd7: op = OP_REMUW; default: op = OP_ILLEGAL;
                    endcase
                end
            end
            OPC_OP_IMM: begin
                case (f3)
                    3'd0: op = OP_ADDI;
                    3'd1: op = (instr[31:26] == 6'b000000) ? OP_SLLI : OP_ILLEGAL;
                    3'd2: op = OP_SLTI;
                    3'd3: op = OP_SLTIU;
                    3'd4: op = OP_XORI;
                    3'd5: op = (instr[31:26] == 6'b000000) ? OP_SRLI :
                               (instr[31:26] == 6'b010000) ? OP_SRAI : OP_ILLEGAL;
                    3'd6: op = OP_ORI;
                    default: op = OP_ANDI;
                endcase
            end
            OPC_OP_IMM32: begin
                if (f3 == 3'd0)                      op = OP_ADDIW;
                else if (f3 == 3'd1 && f7 == F7_BASE) op = OP_SLLIW;
                else if (f3 == 3'd5 && f7 == F7_BASE) op = OP_SRLIW;
                else if (f3 == 3'd5 && f7 == F7_ALT)  op = OP_SRAIW;
            end
            OPC_LUI:   op = OP_LUI;
            OPC_AUIPC: op = OP_AUIPC;
            OPC_JAL:   op = OP_JAL;
            OPC_JALR:  op = (f3 == 3'd0) ? OP_JALR : OP_ILLEGAL;
            default:   op = OP_ILLEGAL;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register file: two combinational read ports, one write port.
//   clk, rst_n          : clock, async active-low clear of every register
//   we, waddr, wdata    : write port (writes to x0 are dropped)
//   raddr1/2, rdata1/2  : read ports, x0 always reads as zero
module regfile_2r1w
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      raddr1,
    input  logic [4:0]      raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (we && waddr != 5'd0) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage between fetch and execute.
//   clk, reset (async, active-low)
//   if_valid/if_ready/if_instr/if_pc : instruction handshake from fetch
//   wb_en/wb_rd/wb_data              : writeback into the register file
//   data_ack                         : execute consumes the output slot
//   id_valid, opcode, rd, rs1_val, rs2_val, immediate, idex_npc, illegal :
//                                      registered output slot
module decode_issue
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            data_ack,
    output logic            id_valid,
    output op_e             opcode,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] rs1_val,
    output logic [XLEN-1:0] rs2_val,
    output logic [XLEN-1:0] immediate,
    output logic [XLEN-1:0] idex_npc,
    output logic            illegal
);

    logic [4:0]      rs1_a, rs2_a, dec_rd;
    op_e             dec_op;
    logic            dec_ill, use_rs1, use_rs2;
    logic [XLEN-1:0] dec_imm, rf_rd1, rf_rd2, rs1_fwd, rs2_fwd;
    logic [NREG-1:0] pending, pending_nxt;
    logic            haz_rs1, haz_rs2, haz_waw, hazard, issue;

    assign rs1_a   = if_instr[19:15];
    assign rs2_a   = if_instr[24:20];
    assign dec_op  = decode_op(if_instr);
    assign dec_ill = (dec_op == OP_ILLEGAL);
    assign dec_rd  = dec_ill ? 5'd0 : if_instr[11:7];

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        dec_imm = '0;
        case (if_instr[6:0])
            OPC_OP, OPC_OP32: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OPC_OP_IMM: begin
                use_rs1 = 1'b1;
                if (if_instr[13:12] == 2'b01)
                    dec_imm = {{(XLEN-6){1'b0}}, if_instr[25:20]};
                else
                    dec_imm = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
            end
            OPC_OP_IMM32: begin
                use_rs1 = 1'b1;
                if (if_instr[13:12] == 2'b01)
                    dec_imm = {{(XLEN-5){1'b0}}, if_instr[24:20]};
                else
                    dec_imm = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
            end
            OPC_JALR: begin
                use_rs1 = 1'b1;
                dec_imm = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
            end
            // Execute uses the U-immediate as-is, so it is pre-shifted here.
            OPC_LUI, OPC_AUIPC:
                dec_imm = {{(XLEN-32){if_instr[31]}}, if_instr[31:12], 12'b0};
            OPC_JAL:
                dec_imm = {{(XLEN-21){if_instr[31]}}, if_instr[31], if_instr[19:12],
                           if_instr[20], if_instr[30:21], 1'b0};
            default: ;
        endcase
        if (dec_ill) begin
            use_rs1 = 1'b0;
            use_rs2 = 1'b0;
            dec_imm = '0;
        end
    end

    regfile_2r1w u_regfile (
        .clk    (clk),
        .rst_n  (reset),
        .we     (wb_en),
        .waddr  (wb_rd),
        .wdata  (wb_data),
        .raddr1 (rs1_a),
        .raddr2 (rs2_a),
        .rdata1 (rf_rd1),
        .rdata2 (rf_rd2)
    );

    // Same-cycle writeback is forwarded so a dependent instruction issues without a bubble.
    assign rs1_fwd = (rs1_a == 5'd0) ? '0 : (wb_en && wb_rd == rs1_a) ? wb_data : rf_rd1;
    assign rs2_fwd = (rs2_a == 5'd0) ? '0 : (wb_en && wb_rd == rs2_a) ? wb_data : rf_rd2;

    assign haz_rs1  = use_rs1 && pending[rs1_a] && !(wb_en && wb_rd == rs1_a);
    assign haz_rs2  = use_rs2 && pending[rs2_a] && !(wb_en && wb_rd == rs2_a);
    assign haz_waw  = (dec_rd != 5'd0) && pending[dec_rd];
    assign hazard   = haz_rs1 || haz_rs2 || haz_waw;
    assign if_ready = reset && !hazard && (!id_valid || data_ack);
    assign issue    = if_valid && if_ready;

    // Set is applied after clear so a new writer of a register being written back stays pending.
    always_comb begin
        pending_nxt = pending;
        if (wb_en && wb_rd != 5'd0) pending_nxt[wb_rd] = 1'b0;
        if (issue && dec_rd != 5'd0) pending_nxt[dec_rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pending <= '0;
        else        pending <= pending_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_valid  <= 1'b0;
            illegal   <= 1'b0;
            opcode    <= OP_ILLEGAL;
            rd        <= 5'd0;
            rs1_val   <= '0;
            rs2_val   <= '0;
            immediate <= '0;
            idex_npc  <= '0;
        end else if (issue) begin
            id_valid  <= 1'b1;
            illegal   <= dec_ill;
            opcode    <= dec_op;
            rd        <= dec_rd;
            rs1_val   <= rs1_fwd;
            rs2_val   <= rs2_fwd;
            immediate <= dec_imm;
            idex_npc  <= if_pc;
        end else if (data_ack) begin
            id_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_issue.sv
module tb_decode_issue;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid, if_ready;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        data_ack;
    logic        id_valid;
    op_e         opcode;
    logic [4:0]  rd;
    logic [63:0] rs1_val, rs2_val, immediate, idex_npc;
    logic        illegal;

    decode_issue dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc), .wb_en(wb_en), .wb_rd(wb_rd),
        .wb_data(wb_data), .data_ack(data_ack), .id_valid(id_valid),
        .opcode(opcode), .rd(rd), .rs1_val(rs1_val), .rs2_val(rs2_val),
        .immediate(immediate), .idex_npc(idex_npc), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        op_e         op;
        logic [4:0]  rd;
        logic [63:0] imm;
        logic        ill;
        bit          c1;
        bit          c2;
    } vec_t;

    typedef struct {
        op_e         op;
        logic [4:0]  rd;
        logic [63:0] rs1, rs2, imm, npc;
        logic        ill;
        bit          c1, c2;
    } exp_t;

    int          tests = 0;
    int          fails = 0;
    logic [63:0] model_rf [32];
    exp_t        sb [$];
    vec_t        vt [14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input op_e op, input logic [4:0] r, input logic [63:0] a,
                                input logic [63:0] b, input logic [63:0] imm,
                                input logic [63:0] npc, input logic ill, input bit c1, input bit c2);
        exp_t e;
        e.op = op; e.rd = r; e.rs1 = a; e.rs2 = b; e.imm = imm;
        e.npc = npc; e.ill = ill; e.c1 = c1; e.c2 = c2;
        return e;
    endfunction

    task automatic check_slot(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_id_valid"}, 64'(id_valid), 64'd1);
        chk({tag, "_opcode"}, 64'(opcode), 64'(e.op));
        chk({tag, "_rd"}, 64'(rd), 64'(e.rd));
        chk({tag, "_imm"}, immediate, e.imm);
        chk({tag, "_npc"}, idex_npc, e.npc);
        chk({tag, "_illegal"}, 64'(illegal), 64'(e.ill));
        if (e.c1) chk({tag, "_rs1"}, rs1_val, e.rs1);
        if (e.c2) chk({tag, "_rs2"}, rs2_val, e.rs2);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_id_valid"}, 64'(id_valid), 64'd0);
        chk({tag, "_illegal"}, 64'(illegal), 64'd0);
        chk({tag, "_opcode"}, 64'(opcode), 64'd0);
        chk({tag, "_rd"}, 64'(rd), 64'd0);
        chk({tag, "_rs1"}, rs1_val, 64'd0);
        chk({tag, "_rs2"}, rs2_val, 64'd0);
        chk({tag, "_imm"}, immediate, 64'd0);
        chk({tag, "_npc"}, idex_npc, 64'd0);
        chk({tag, "_if_ready"}, 64'(if_ready), 64'd0);
    endtask

    task automatic drive_issue(input string tag, input logic [31:0] instr,
                               input logic [63:0] pc, input exp_t e, output int waits);
        if_instr = instr;
        if_pc    = pc;
        if_valid = 1'b1;
        waits    = 0;
        #1;
        while (!if_ready && waits < 20) begin
            @(posedge clk); #1;
            waits++;
        end
        if (!if_ready) begin
            chk({tag, "_issue_timeout"}, 64'(if_ready), 64'd1);
            if_valid = 1'b0;
            return;
        end
        sb.push_back(e);
        @(posedge clk); #1;
        if_valid = 1'b0;
        check_slot(tag);
    endtask

    task automatic wb(input logic [4:0] r, input logic [63:0] v);
        wb_en = 1'b1; wb_rd = r; wb_data = v;
        @(posedge clk); #1;
        wb_en = 1'b0;
        if (r != 5'd0) model_rf[r] = v;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int   w;
        exp_t e;
        reset = 1'b0; if_valid = 1'b1; if_instr = 32'h0050_0093; if_pc = '0;
        wb_en = 1'b0; wb_rd = '0; wb_data = '0; data_ack = 1'b1;
        for (int i = 0; i < 32; i++) model_rf[i] = '0;

        vt[0]  = '{32'h006103B3, OP_ADD,     5'd7,  64'h0,                 1'b0, 1'b1, 1'b1};
        vt[1]  = '{32'h40220433, OP_SUB,     5'd8,  64'h0,                 1'b0, 1'b1, 1'b1};
        vt[2]  = '{32'h024104B3, OP_MUL,     5'd9,  64'h0,                 1'b0, 1'b1, 1'b1};
        vt[3]  = '{32'hFFF3051B, OP_ADDIW,   5'd10, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b1, 1'b0};
        vt[4]  = '{32'h41F2559B, OP_SRAIW,   5'd11, 64'h1F,               1'b0, 1'b1, 1'b0};
        vt[5]  = '{32'h03F11613, OP_SLLI,    5'd12, 64'h3F,               1'b0, 1'b1, 1'b0};
        vt[6]  = '{32'hFFDFF6EF, OP_JAL,     5'd13, 64'hFFFFFFFFFFFFFFFC, 1'b0, 1'b0, 1'b0};
        vt[7]  = '{32'h00830767, OP_JALR,    5'd14, 64'h8,                1'b0, 1'b1, 1'b0};
        vt[8]  = '{32'h80000797, OP_AUIPC,   5'd15, 64'hFFFFFFFF80000000, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{32'hFFFFF2B7, OP_LUI,     5'd5,  64'hFFFFFFFFFFFFF000, 1'b0, 1'b0, 1'b0};
        vt[10] = '{32'h4030D093, OP_SRAI,    5'd1,  64'h3,                1'b0, 1'b1, 1'b0};
        vt[11] = '{32'h00000000, OP_ILLEGAL, 5'd0,  64'h0,                1'b1, 1'b0, 1'b0};
        vt[12] = '{32'h40221433, OP_ILLEGAL, 5'd0,  64'h0,                1'b1, 1'b0, 1'b0};
        vt[13] = '{32'h024158BB, OP_DIVUW,   5'd17, 64'h0,                1'b0, 1'b1, 1'b1};

        #3;
        check_zero("reset");
        @(posedge clk); #1;
        reset = 1'b1; if_valid = 1'b0;

        // addi x1,x0,5 then dependent add x3,x1,x2 released by a bypassed writeback
        drive_issue("addi_x1", 32'h00500093, 64'h100,
                    mk(OP_ADDI, 5'd1, 64'd0, 64'd0, 64'd5, 64'h100, 1'b0, 1'b1, 1'b0), w);
        if_instr = 32'h002081B3; if_pc = 64'h104; if_valid = 1'b1;
        #1;
        chk("raw_stall", 64'(if_ready), 64'd0);
        @(posedge clk); #1;
        chk("raw_bubble", 64'(id_valid), 64'd0);
        chk("raw_stall2", 64'(if_ready), 64'd0);
        wb_en = 1'b1; wb_rd = 5'd1; wb_data = 64'd5;
        #1;
        chk("raw_bypass_ready", 64'(if_ready), 64'd1);
        sb.push_back(mk(OP_ADD, 5'd3, 64'd5, 64'd0, 64'd0, 64'h104, 1'b0, 1'b1, 1'b1));
        @(posedge clk); #1;
        if_valid = 1'b0; wb_en = 1'b0; data_ack = 1'b0;
        model_rf[1] = 64'd5;
        check_slot("add_bypass");

        // held slot: outputs stable and if_ready low while data_ack=0
        wb_en = 1'b1; wb_rd = 5'd3; wb_data = 64'h33;
        if_instr = 32'h00700A13; if_pc = 64'h108; if_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_if_ready", 64'(if_ready), 64'd0);
            @(posedge clk); #1;
            wb_en = 1'b0;
            chk("hold_id_valid", 64'(id_valid), 64'd1);
            chk("hold_opcode", 64'(opcode), 64'(OP_ADD));
            chk("hold_rs1", rs1_val, 64'd5);
            chk("hold_rd", 64'(rd), 64'd3);
        end
        model_rf[3] = 64'h33;
        data_ack = 1'b1;
        #1;
        chk("ack_ready", 64'(if_ready), 64'd1);
        sb.push_back(mk(OP_ADDI, 5'd20, 64'd0, 64'd0, 64'd7, 64'h108, 1'b0, 1'b1, 1'b0));
        @(posedge clk); #1;
        if_valid = 1'b0;
        check_slot("addi_after_ack");

        // x0 writes are dropped, including a same-cycle writeback to x0
        wb(5'd0, 64'hDEAD);
        wb_en = 1'b1; wb_rd = 5'd0; wb_data = 64'hDEAD;
        drive_issue("x0_read", 32'h00100A93, 64'h10C,
                    mk(OP_ADDI, 5'd21, 64'd0, 64'd0, 64'd1, 64'h10C, 1'b0, 1'b1, 1'b0), w);
        wb_en = 1'b0;

        wb(5'd2, 64'h1234);
        wb(5'd4, 64'hFFFFFFFFFFFFFFF9);
        wb(5'd6, 64'h10);

        for (int i = 0; i < 14; i++) begin
            e = mk(vt[i].op, vt[i].rd, model_rf[vt[i].instr[19:15]], model_rf[vt[i].instr[24:20]],
                   vt[i].imm, 64'h1000 + 64'(4 * i), vt[i].ill, vt[i].c1, vt[i].c2);
            drive_issue($sformatf("vec%0d", i), vt[i].instr, 64'h1000 + 64'(4 * i), e, w);
            chk($sformatf("vec%0d_nostall", i), 64'(w), 64'd0);
            if (vt[i].rd != 5'd0) wb(vt[i].rd, 64'hC0DE_0000_0000_0000 | 64'(i));
        end

        // an illegal op with rd field 8 must not mark x8 pending (back-to-back issue)
        drive_issue("ill_rd8", 32'h40221433, 64'h300,
                    mk(OP_ILLEGAL, 5'd0, 64'd0, 64'd0, 64'd0, 64'h300, 1'b1, 1'b0, 1'b0), w);
        drive_issue("addi_x8", 32'h00100413, 64'h304,
                    mk(OP_ADDI, 5'd8, 64'd0, 64'd0, 64'd1, 64'h304, 1'b0, 1'b1, 1'b0), w);
        chk("addi_x8_nostall", 64'(w), 64'd0);
        wb(5'd8, 64'h88);

        // issue-set beats same-cycle writeback-clear on x22
        wb_en = 1'b1; wb_rd = 5'd22; wb_data = 64'h77;
        drive_issue("set_wins_issue", 32'h00300B13, 64'h308,
                    mk(OP_ADDI, 5'd22, 64'd0, 64'd0, 64'd3, 64'h308, 1'b0, 1'b1, 1'b0), w);
        wb_en = 1'b0;
        if_instr = 32'h000B0B93; if_pc = 64'h30C; if_valid = 1'b1;
        #1;
        chk("set_wins", 64'(if_ready), 64'd0);
        if_valid = 1'b0;
        wb(5'd22, 64'h99);

        // async reset while a full slot is stalled
        data_ack = 1'b0;
        drive_issue("pre_reset", 32'h00900D13, 64'h200,
                    mk(OP_ADDI, 5'd26, 64'd0, 64'd0, 64'd9, 64'h200, 1'b0, 1'b1, 1'b0), w);
        if_instr = 32'h00100413; if_valid = 1'b1;
        @(posedge clk); #1;
        chk("stall_valid", 64'(id_valid), 64'd1);
        chk("stall_ready", 64'(if_ready), 64'd0);
        #2;
        reset = 1'b0;
        #1;
        check_zero("mid_reset");
        if_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1; data_ack = 1'b1;
        for (int i = 0; i < 32; i++) model_rf[i] = '0;

        drive_issue("rf_cleared", 32'h00010C33, 64'h400,
                    mk(OP_ADD, 5'd24, 64'd0, 64'd0, 64'd0, 64'h400, 1'b0, 1'b1, 1'b1), w);
        drive_issue("pend_cleared", 32'h000A0C93, 64'h404,
                    mk(OP_ADDI, 5'd25, 64'd0, 64'd0, 64'd0, 64'h404, 1'b0, 1'b1, 1'b0), w);
        chk("pend_cleared_nostall", 64'(w), 64'd0);

        @(posedge clk); #1;
        chk("drain", 64'(id_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
